// File: rtl/enc42_seq.sv
`default_nettype none
// ============================================================================
//  Module   : enc42_seq
//  Purpose  : Sequential 4-to-2 priority encoder. Latches rising edges on four
//             request lines and emits one 2-bit code per event over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module enc42_seq #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [1:0] code,
    output logic [3:0] pend,
    output logic       ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_req_q;
    logic [3:0] r_pending;
    logic       r_out_valid;
    logic [1:0] r_code;
    logic       r_ovf;

    logic [3:0] w_edge;
    logic       w_any;
    logic [1:0] w_sel;
    logic       w_load;
    logic [3:0] w_load_mask;
    logic       w_ovf_set;

    assign w_edge = req & ~r_req_q;
    assign w_any  = |r_pending;

    // Only already-registered pending bits compete; fresh edges wait a cycle.
    generate
        if (PRIO_HIGH) begin : g_prio_high
            always_comb begin
                w_sel = 2'd0;
                for (int i = 0; i < 4; i++) begin
                    if (r_pending[i]) w_sel = i[1:0];
                end
            end
        end else begin : g_prio_low
            always_comb begin
                w_sel = 2'd0;
                for (int i = 3; i >= 0; i--) begin
                    if (r_pending[i]) w_sel = i[1:0];
                end
            end
        end
    endgenerate

    assign w_load      = w_any && ((r_state == ST_IDLE) || out_ready);
    assign w_load_mask = w_load ? (4'b0001 << w_sel) : 4'b0000;
    assign w_ovf_set   = |(w_edge & r_pending & ~w_load_mask);

    always_ff @(posedge clk) begin
        r_req_q <= req;
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 4'b0000;
            r_out_valid <= 1'b0;
            r_code      <= 2'b00;
            r_ovf       <= 1'b0;
        end else begin
            // A new edge overrides the clear from a same-cycle load.
            r_pending <= (r_pending & ~w_load_mask) | w_edge;

            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_code      <= w_sel;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (w_load) begin
                            r_code <= w_sel;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign code      = r_code;
    assign pend      = r_pending;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_enc42_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enc42_seq
//  Purpose  : Directed self-checking bench for enc42_seq, both priority orders.
//  Revision : 1.0  initial release
// ============================================================================
module tb_enc42_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic       ovf_clr;

    logic       hi_valid, lo_valid;
    logic [1:0] hi_code,  lo_code;
    logic [3:0] hi_pend,  lo_pend;
    logic       hi_ovf,   lo_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    enc42_seq #(.PRIO_HIGH(1'b1)) u_dut_hi (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready), .ovf_clr(ovf_clr),
        .out_valid(hi_valid), .code(hi_code), .pend(hi_pend), .ovf(hi_ovf)
    );

    enc42_seq #(.PRIO_HIGH(1'b0)) u_dut_lo (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready), .ovf_clr(ovf_clr),
        .out_valid(lo_valid), .code(lo_code), .pend(lo_pend), .ovf(lo_ovf)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge; outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both instances see the same stimulus; check each against its own expectation.
    task automatic check_both(input string tag,
                              input logic v_hi, input logic [1:0] c_hi, input logic [3:0] p_hi,
                              input logic v_lo, input logic [1:0] c_lo, input logic [3:0] p_lo);
        check({tag, " hi valid"}, {7'd0, hi_valid}, {7'd0, v_hi});
        check({tag, " hi code"},  {6'd0, hi_code},  {6'd0, c_hi});
        check({tag, " hi pend"},  {4'd0, hi_pend},  {4'd0, p_hi});
        check({tag, " lo valid"}, {7'd0, lo_valid}, {7'd0, v_lo});
        check({tag, " lo code"},  {6'd0, lo_code},  {6'd0, c_lo});
        check({tag, " lo pend"},  {4'd0, lo_pend},  {4'd0, p_lo});
    endtask

    logic [3:0] dec;

    initial begin
        rst = 1'b1; req = 4'b0100; out_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        check_both("reset", 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        check("reset ovf", {7'd0, hi_ovf}, 8'd0);

        // Line held high through reset must not fire.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both("held", 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        end
        req = 4'b0000;
        step();

        // Single pulse on line 1.
        req = 4'b0010; out_ready = 1'b1;
        step();
        check_both("pulse N", 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 4'b0010);
        req = 4'b0000;
        step();
        check_both("pulse N+1", 1'b1, 2'd1, 4'h0, 1'b1, 2'd1, 4'h0);
        dec = 4'b0001 << {hi_code[1], hi_code[0]};
        check("decode", {4'd0, dec}, 8'b0010);
        step();
        check_both("pulse N+2", 1'b0, 2'd1, 4'h0, 1'b0, 2'd1, 4'h0);

        // Simultaneous rise on lines 3,1,0.
        req = 4'b1011;
        step();
        check_both("multi set", 1'b0, 2'd1, 4'b1011, 1'b0, 2'd1, 4'b1011);
        req = 4'b0000;
        step();
        check_both("multi 1st", 1'b1, 2'd3, 4'b0011, 1'b1, 2'd0, 4'b1010);
        step();
        check_both("multi 2nd", 1'b1, 2'd1, 4'b0001, 1'b1, 2'd1, 4'b1000);
        step();
        check_both("multi 3rd", 1'b1, 2'd0, 4'b0000, 1'b1, 2'd3, 4'b0000);
        step();
        check_both("multi idle", 1'b0, 2'd0, 4'b0000, 1'b0, 2'd3, 4'b0000);

        // Stall with code 3 presented.
        out_ready = 1'b0; req = 4'b1000;
        step();
        req = 4'b0000;
        step();
        check_both("stall load", 1'b1, 2'd3, 4'h0, 1'b1, 2'd3, 4'h0);
        req = 4'b0100;
        step();
        check_both("stall hold", 1'b1, 2'd3, 4'b0100, 1'b1, 2'd3, 4'b0100);
        req = 4'b0010;
        step();
        check_both("stall two", 1'b1, 2'd3, 4'b0110, 1'b1, 2'd3, 4'b0110);
        check("no ovf yet", {7'd0, hi_ovf}, 8'd0);

        // Second rise on pending line 1 while stalled -> overflow.
        req = 4'b0000;
        step();
        req = 4'b0010;
        step();
        check("ovf set hi", {7'd0, hi_ovf}, 8'd1);
        check("ovf set lo", {7'd0, lo_ovf}, 8'd1);
        check_both("ovf pend", 1'b1, 2'd3, 4'b0110, 1'b1, 2'd3, 4'b0110);
        req = 4'b0000; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf clr hi", {7'd0, hi_ovf}, 8'd0);
        check("ovf clr lo", {7'd0, lo_ovf}, 8'd0);

        // Release stall; then rise on line 1 as hi loads line 1.
        out_ready = 1'b1;
        step();
        check_both("release", 1'b1, 2'd2, 4'b0010, 1'b1, 2'd1, 4'b0100);
        req = 4'b0010;
        step();
        check_both("set wins", 1'b1, 2'd1, 4'b0010, 1'b1, 2'd2, 4'b0010);
        check("set wins ovf hi", {7'd0, hi_ovf}, 8'd0);
        check("set wins ovf lo", {7'd0, lo_ovf}, 8'd0);
        req = 4'b0000;
        step();
        check_both("reload", 1'b1, 2'd1, 4'h0, 1'b1, 2'd1, 4'h0);

        // Reset while holding with pending events.
        out_ready = 1'b0; req = 4'b0101;
        step();
        check_both("pre rst", 1'b1, 2'd1, 4'b0101, 1'b1, 2'd1, 4'b0101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_both("mid rst", 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);
        check("mid rst ovf", {7'd0, hi_ovf}, 8'd0);
        step();
        check_both("post rst", 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
